// File: rtl/scanchain_host_driver.sv
// Tester-side scan-chain master: LOAD -> RUN -> CAPTURE -> UNLOAD -> RESP.
// Optional readback compare of the input field: SCANCHAIN_READBACK_CHECK_EN.
module scanchain_host_driver #(
    parameter int SC_INPUT_LENGTH  = 64,
    parameter int SC_OUTPUT_LENGTH = 64,
    parameter int SC_TOTAL_LENGTH  = SC_INPUT_LENGTH + SC_OUTPUT_LENGTH,
    parameter int RUN_CNT_WIDTH    = 16
) (
    input  logic                       scan_clk,
    input  logic                       rst_b,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [SC_INPUT_LENGTH-1:0] cmd_data_in,
    input  logic [RUN_CNT_WIDTH-1:0]   cmd_run_cycles,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [SC_TOTAL_LENGTH-1:0] rsp_data,
    output logic                       rsp_mismatch,
    output logic                       busy,
    output logic [1:0]                 scan_state_ctl_signal,
    output logic                       scan_in,
    output logic                       en_run,
    input  logic                       scan_out
);
    localparam int T  = SC_TOTAL_LENGTH;
    localparam int CW = $clog2(T + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_UNLOAD, S_RESP
    } state_t;

    state_t                   r_state,   w_state_nxt;
    logic [1:0]               r_ctl,     w_ctl_nxt;
    logic                     r_scan_in, w_scan_in_nxt;
    logic                     r_en_run,  w_en_run_nxt;
    logic                     r_rsp_vld, w_rsp_vld_nxt;
    logic [T-1:0]             r_load_sr, w_load_sr_nxt;
    logic [T-1:0]             r_rsp_sr,  w_rsp_sr_nxt;
    logic [CW-1:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic [RUN_CNT_WIDTH-1:0] r_run_cnt, w_run_cnt_nxt;
    logic [T-1:0]             w_cmd_word;
    logic [T-1:0]             w_unload_word;
    logic                     w_last_bit;

    assign w_cmd_word    = {{SC_OUTPUT_LENGTH{1'b0}}, cmd_data_in};
    assign w_unload_word = {r_rsp_sr[T-2:0], scan_out};
    assign w_last_bit    = (r_bit_cnt == CW'(1));

    always_comb begin
        w_state_nxt   = r_state;
        w_ctl_nxt     = r_ctl;
        w_scan_in_nxt = r_scan_in;
        w_en_run_nxt  = 1'b0;
        w_rsp_vld_nxt = r_rsp_vld;
        w_load_sr_nxt = r_load_sr;
        w_rsp_sr_nxt  = r_rsp_sr;
        w_bit_cnt_nxt = r_bit_cnt;
        w_run_cnt_nxt = r_run_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_ctl_nxt = 2'b00;
                if (cmd_valid) begin
                    // scan_in is registered, so the first chain bit goes out now
                    w_state_nxt   = S_LOAD;
                    w_ctl_nxt     = 2'b01;
                    w_scan_in_nxt = w_cmd_word[T-1];
                    w_load_sr_nxt = w_cmd_word << 1;
                    w_bit_cnt_nxt = CW'(T);
                    w_run_cnt_nxt = cmd_run_cycles;
                end
            end
            S_LOAD: begin
                w_scan_in_nxt = r_load_sr[T-1];
                w_load_sr_nxt = r_load_sr << 1;
                w_bit_cnt_nxt = r_bit_cnt - CW'(1);
                if (w_last_bit) begin
                    w_scan_in_nxt = 1'b0;
                    if (r_run_cnt != '0) begin
                        w_state_nxt  = S_RUN;
                        w_ctl_nxt    = 2'b10;
                        w_en_run_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                        w_ctl_nxt   = 2'b11;
                    end
                end
            end
            S_RUN: begin
                w_run_cnt_nxt = r_run_cnt - RUN_CNT_WIDTH'(1);
                w_en_run_nxt  = 1'b1;
                if (r_run_cnt == RUN_CNT_WIDTH'(1)) begin
                    w_state_nxt  = S_CAPTURE;
                    w_ctl_nxt    = 2'b11;
                    w_en_run_nxt = 1'b0;
                end
            end
            S_CAPTURE: begin
                w_state_nxt   = S_UNLOAD;
                w_ctl_nxt     = 2'b01;
                w_scan_in_nxt = 1'b0;
                w_bit_cnt_nxt = CW'(T);
            end
            S_UNLOAD: begin
                w_rsp_sr_nxt  = w_unload_word;
                w_bit_cnt_nxt = r_bit_cnt - CW'(1);
                if (w_last_bit) begin
                    w_state_nxt   = S_RESP;
                    w_ctl_nxt     = 2'b00;
                    w_rsp_vld_nxt = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_rsp_vld_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ctl_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge scan_clk) begin
        if (!rst_b) begin
            r_state   <= S_IDLE;
            r_ctl     <= 2'b00;
            r_scan_in <= 1'b0;
            r_en_run  <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_load_sr <= '0;
            r_rsp_sr  <= '0;
            r_bit_cnt <= '0;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ctl     <= w_ctl_nxt;
            r_scan_in <= w_scan_in_nxt;
            r_en_run  <= w_en_run_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
            r_load_sr <= w_load_sr_nxt;
            r_rsp_sr  <= w_rsp_sr_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_run_cnt <= w_run_cnt_nxt;
        end
    end

`ifdef SCANCHAIN_READBACK_CHECK_EN
    logic [SC_INPUT_LENGTH-1:0] r_loaded;
    logic                       r_mismatch;
    logic                       w_load_en;
    logic                       w_resp_en;
    logic                       w_resp_hs;

    assign w_load_en = (r_state == S_IDLE) && cmd_valid;
    assign w_resp_en = (r_state == S_UNLOAD) && w_last_bit;
    assign w_resp_hs = (r_state == S_RESP) && rsp_ready;

    // Capture leaves the input field untouched, so it must read back as loaded
    always_ff @(posedge scan_clk) begin
        if (!rst_b) begin
            r_loaded   <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_load_en)
                r_loaded <= cmd_data_in;
            if (w_resp_en)
                r_mismatch <= (w_unload_word[SC_INPUT_LENGTH-1:0] != r_loaded);
            else if (w_resp_hs)
                r_mismatch <= 1'b0;
        end
    end

    assign rsp_mismatch = r_mismatch;
`else
    assign rsp_mismatch = 1'b0;
`endif

    assign cmd_ready             = (r_state == S_IDLE);
    assign busy                  = (r_state != S_IDLE);
    assign rsp_valid             = r_rsp_vld;
    assign rsp_data              = r_rsp_sr;
    assign scan_state_ctl_signal = r_ctl;
    assign scan_in               = r_scan_in;
    assign en_run                = r_en_run;

endmodule

// File: tb/tb_scanchain_host_driver.sv
// Directed bench for scanchain_host_driver with a behavioural 16-bit chip chain.
// Readback expectations follow SCANCHAIN_READBACK_CHECK_EN when defined.
module tb_scanchain_host_driver;
    localparam int IN = 8;
    localparam int OUT = 8;
    localparam int T = 16;
    localparam int RW = 16;

    logic          scan_clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IN-1:0] cmd_data_in = '0;
    logic [RW-1:0] cmd_run_cycles = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [T-1:0]  rsp_data;
    logic          rsp_mismatch;
    logic          busy;
    logic [1:0]    scan_state_ctl_signal;
    logic          scan_in;
    logic          en_run;
    logic          scan_out;

    int n_vec = 0;
    int n_miss = 0;

    logic [T-1:0] chain = '0;
    logic [1:0]   prev_ctl = 2'b00;
    logic [7:0]   model_out = 8'h00;
    logic         fault_req = 1'b0;

    scanchain_host_driver #(
        .SC_INPUT_LENGTH(IN), .SC_OUTPUT_LENGTH(OUT),
        .SC_TOTAL_LENGTH(T), .RUN_CNT_WIDTH(RW)
    ) dut (
        .scan_clk(scan_clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data_in(cmd_data_in), .cmd_run_cycles(cmd_run_cycles),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_mismatch(rsp_mismatch), .busy(busy),
        .scan_state_ctl_signal(scan_state_ctl_signal),
        .scan_in(scan_in), .en_run(en_run), .scan_out(scan_out)
    );

    always #5 scan_clk = ~scan_clk;

    // Chip model: shift on 01, optional single bit-2 upset on first RUN cycle,
    // capture core outputs into the high field on 11.
    assign scan_out = chain[T-1];
    always @(posedge scan_clk) begin
        prev_ctl <= scan_state_ctl_signal;
        case (scan_state_ctl_signal)
            2'b01: chain <= {chain[T-2:0], scan_in};
            2'b10: if (fault_req && prev_ctl != 2'b10) chain[2] <= ~chain[2];
            2'b11: chain[T-1:IN] <= model_out;
            default: ;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_txn(input logic [7:0] data, input int n,
                           input logic [7:0] mdl, input logic fault,
                           input logic pulse, input int hold,
                           input logic [T-1:0] exp_rsp, input logic exp_mis);
        logic [1:0]   exp_ctl;
        logic [T-1:0] held;
        int           e;
        model_out = mdl;
        fault_req = fault;
        @(negedge scan_clk);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_data_in = data;
        cmd_run_cycles = RW'(n);
        @(posedge scan_clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k <= 2*T + n; k++) begin
            e = k + 1;
            if (e <= T) exp_ctl = 2'b01;
            else if (e <= T + n) exp_ctl = 2'b10;
            else if (e == T + n + 1) exp_ctl = 2'b11;
            else exp_ctl = 2'b01;
            n_vec++;
            if ({scan_state_ctl_signal, en_run, rsp_valid, cmd_ready, busy} !==
                {exp_ctl, exp_ctl == 2'b10, 1'b0, 1'b0, 1'b1}) begin
                n_miss++;
                $display("FAIL seq edge %0d: ctl/en/vld/rdy/busy got %b%b%b%b%b want %b%b001",
                         k, scan_state_ctl_signal, en_run, rsp_valid, cmd_ready,
                         busy, exp_ctl, exp_ctl == 2'b10);
            end
            if (pulse && k == 3) begin
                cmd_valid = 1'b1;
                cmd_data_in = 8'hFF;
                cmd_run_cycles = 16'd1;
            end
            if (pulse && k == 5) cmd_valid = 1'b0;
            @(posedge scan_clk); #1;
        end
        n_vec++;
        if ({rsp_valid, rsp_data, rsp_mismatch, scan_state_ctl_signal, cmd_ready}
            !== {1'b1, exp_rsp, exp_mis, 2'b00, 1'b0}) begin
            n_miss++;
            $display("FAIL resp: vld=%b data=%h mis=%b ctl=%b rdy=%b want 1 %h %b 00 0",
                     rsp_valid, rsp_data, rsp_mismatch, scan_state_ctl_signal,
                     cmd_ready, exp_rsp, exp_mis);
        end
        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            if (h == 2) begin
                cmd_valid = 1'b1;
                cmd_data_in = 8'h11;
                cmd_run_cycles = 16'd0;
            end
            @(posedge scan_clk); #1;
            n_vec++;
            if ({rsp_valid, cmd_ready, busy, rsp_data, rsp_mismatch, en_run} !==
                {1'b1, 1'b0, 1'b1, held, exp_mis, 1'b0}) begin
                n_miss++;
                $display("FAIL hold %0d: vld=%b rdy=%b busy=%b data=%h mis=%b want 1 0 1 %h %b",
                         h, rsp_valid, cmd_ready, busy, rsp_data, rsp_mismatch,
                         held, exp_mis);
            end
        end
        rsp_ready = 1'b1;
        @(posedge scan_clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        n_vec++;
        if ({rsp_valid, cmd_ready, busy, scan_state_ctl_signal, rsp_mismatch}
            !== {1'b0, 1'b1, 1'b0, 2'b00, 1'b0}) begin
            n_miss++;
            $display("FAIL handshake: vld=%b rdy=%b busy=%b ctl=%b mis=%b want 0 1 0 00 0",
                     rsp_valid, cmd_ready, busy, scan_state_ctl_signal, rsp_mismatch);
        end
        fault_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge scan_clk);
        #1;
        n_vec++;
        if ({scan_state_ctl_signal, scan_in, en_run, rsp_valid, rsp_data,
             rsp_mismatch, busy} !== {2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_vals: ctl=%b si=%b en=%b vld=%b data=%h mis=%b busy=%b",
                     scan_state_ctl_signal, scan_in, en_run, rsp_valid, rsp_data,
                     rsp_mismatch, busy);
        end
        rst_b = 1'b1;
        @(posedge scan_clk); #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        rsp_ready = 1'b1;
        repeat (2) @(posedge scan_clk);
        #1;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            n_miss++;
            $display("FAIL early_rsp_ready: vld/busy/rdy got %b%b%b want 001",
                     rsp_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_basic();
        run_txn(8'hA5, 3, 8'h3C, 1'b0, 1'b0, 0, 16'h3CA5, 1'b0);
    endtask

    task automatic test_zero_run();
        run_txn(8'h0F, 0, 8'h00, 1'b0, 1'b0, 0, 16'h000F, 1'b0);
    endtask

    task automatic test_hold_resp();
        run_txn(8'h96, 1, 8'hE7, 1'b0, 1'b0, 10, 16'hE796, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge scan_clk);
        cmd_valid = 1'b1;
        cmd_data_in = 8'hC3;
        cmd_run_cycles = 16'd5;
        @(posedge scan_clk); #1;
        cmd_valid = 1'b0;
        repeat (17) @(posedge scan_clk);
        #1;
        n_vec++;
        if ({scan_state_ctl_signal, en_run} !== 3'b101) begin
            n_miss++;
            $display("FAIL in_run: ctl=%b en=%b want 10 1", scan_state_ctl_signal, en_run);
        end
        rst_b = 1'b0;
        @(posedge scan_clk); #1;
        rst_b = 1'b1;
        n_vec++;
        if ({scan_state_ctl_signal, en_run, rsp_valid, cmd_ready, busy, rsp_data}
            !== {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            n_miss++;
            $display("FAIL mid_reset: ctl=%b en=%b vld=%b rdy=%b busy=%b data=%h",
                     scan_state_ctl_signal, en_run, rsp_valid, cmd_ready, busy, rsp_data);
        end
        run_txn(8'h5A, 2, 8'h77, 1'b0, 1'b0, 0, 16'h775A, 1'b0);
    endtask

    task automatic test_readback();
        logic exp_mis;
`ifdef SCANCHAIN_READBACK_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        run_txn(8'hA5, 3, 8'h3C, 1'b1, 1'b0, 2, 16'h3CA1, exp_mis);
        run_txn(8'hA5, 3, 8'h3C, 1'b0, 1'b0, 0, 16'h3CA5, 1'b0);
    endtask

    task automatic test_load_pulse();
        run_txn(8'h81, 4, 8'h42, 1'b0, 1'b1, 0, 16'h4281, 1'b0);
        repeat (6) @(posedge scan_clk);
        #1;
        n_vec++;
        if ({rsp_valid, busy, scan_state_ctl_signal} !== 4'b0000) begin
            n_miss++;
            $display("FAIL single_resp: vld=%b busy=%b ctl=%b want 0 0 00",
                     rsp_valid, busy, scan_state_ctl_signal);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_run();
        test_hold_resp();
        test_reset_mid_run();
        test_readback();
        test_load_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
